// File: rtl/matrix_frame_buffer.sv
// rtl/matrix_frame_buffer.sv - double-buffered 8x8 RGB frame store for the matrix row scanner
//
// Ports:
//   clk, reset_n                 clock; asynchronous active-low reset
//   wr_valid/wr_ready            pixel write handshake into the back buffer
//   wr_addr {row,col}, wr_rgb    pixel index and {red, green, blue} intensities
//   wr_commit, commit_pend       frame commit pulse; commit waiting for row0/plane0
//   rd_req, rd_row, rd_plane     scanner fetch request (ignored while rd_busy)
//   rd_busy, rd_valid            fetch/clear in progress; one-cycle result strobe
//   rd_red, rd_blue, rd_green    column bytes for the fetched row and bit-plane
`timescale 1ns/1ps

module matrix_frame_buffer #(
  parameter int PWM_BITS = 4,
  parameter int PLANE_W  = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [5:0]              wr_addr,
  input  logic [3*PWM_BITS-1:0]   wr_rgb,
  input  logic                    wr_commit,
  output logic                    commit_pend,
  input  logic                    rd_req,
  input  logic [2:0]              rd_row,
  input  logic [PLANE_W-1:0]      rd_plane,
  output logic                    rd_busy,
  output logic                    rd_valid,
  output logic [7:0]              rd_red,
  output logic [7:0]              rd_blue,
  output logic [7:0]              rd_green
);

  localparam int W = 3 * PWM_BITS;

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_FETCH, S_DONE} state_t;

  state_t               state, state_nx;
  logic [5:0]           clr_idx;
  logic [3:0]           col_cnt;
  logic [2:0]           row_q;
  logic [PLANE_W-1:0]   plane_q;
  logic                 front_sel;
  logic [7:0]           sh_r, sh_g, sh_b;

  logic                 clr_we;
  logic                 accept;
  logic                 swap;
  logic                 commit_set;
  logic                 wr_fire;

  logic [W-1:0]         mem0 [0:63];
  logic [W-1:0]         mem1 [0:63];
  logic [W-1:0]         q0, q1, q;
  logic [5:0]           rd_addr;
  logic [PWM_BITS-1:0]  red_sh, green_sh, blue_sh;
  logic                 bit_r, bit_g, bit_b;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_CLEAR;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rd_busy  = 1'b1;
    wr_ready = 1'b0;
    clr_we   = 1'b0;
    accept   = 1'b0;
    case (state)
      S_CLEAR: begin
        clr_we = 1'b1;
        if (clr_idx == 6'd63) state_nx = S_IDLE;
      end
      S_IDLE: begin
        rd_busy  = 1'b0;
        wr_ready = !commit_pend;
        if (rd_req) begin
          accept   = 1'b1;
          state_nx = S_FETCH;
        end
      end
      S_FETCH: begin
        wr_ready = !commit_pend;
        // col_cnt 0..7 issue reads; count 8 drains the last RAM word
        if (col_cnt == 4'd8) state_nx = S_DONE;
      end
      S_DONE: begin
        wr_ready = !commit_pend;
        state_nx = S_IDLE;
      end
      default: state_nx = S_CLEAR;
    endcase
  end

  assign wr_fire    = wr_valid && wr_ready;
  // Frame boundary is the start of a scan: row 0, plane 0.
  assign swap       = accept && commit_pend && (rd_row == 3'd0) && (rd_plane == '0);
  assign commit_set = wr_commit && (state != S_CLEAR) && !commit_pend;

  // ---------------- storage ----------------
  // Back buffer is ~front_sel; CLEAR zeroes both buffers at once.
  assign rd_addr = {row_q, col_cnt[2:0]};

  always_ff @(posedge clk) begin
    if (clr_we)                    mem0[clr_idx] <= '0;
    else if (wr_fire && front_sel) mem0[wr_addr] <= wr_rgb;
    q0 <= mem0[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (clr_we)                     mem1[clr_idx] <= '0;
    else if (wr_fire && !front_sel) mem1[wr_addr] <= wr_rgb;
    q1 <= mem1[rd_addr];
  end

  // front_sel cannot change during a fetch, so muxing after the RAM is safe.
  assign q = front_sel ? q1 : q0;

  // Shifting past the field width yields 0, which covers planes >= PWM_BITS.
  assign red_sh   = q[3*PWM_BITS-1:2*PWM_BITS] >> plane_q;
  assign green_sh = q[2*PWM_BITS-1:PWM_BITS]   >> plane_q;
  assign blue_sh  = q[PWM_BITS-1:0]            >> plane_q;
  assign bit_r    = red_sh[0];
  assign bit_g    = green_sh[0];
  assign bit_b    = blue_sh[0];

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_idx     <= '0;
      col_cnt     <= '0;
      row_q       <= '0;
      plane_q     <= '0;
      front_sel   <= 1'b0;
      commit_pend <= 1'b0;
      rd_valid    <= 1'b0;
      rd_red      <= '0;
      rd_blue     <= '0;
      rd_green    <= '0;
      sh_r        <= '0;
      sh_g        <= '0;
      sh_b        <= '0;
    end else begin
      rd_valid <= 1'b0;

      if (state == S_CLEAR) clr_idx <= clr_idx + 6'd1;

      if (accept) begin
        row_q   <= rd_row;
        plane_q <= rd_plane;
        col_cnt <= '0;
      end

      if (swap) begin
        front_sel   <= ~front_sel;
        commit_pend <= 1'b0;
      end else if (commit_set) begin
        commit_pend <= 1'b1;
      end

      if (state == S_FETCH) begin
        col_cnt <= col_cnt + 4'd1;
        // Data for column (col_cnt-1) is on q; shift in from the MSB so
        // column 0 ends up in bit 0.
        if (col_cnt == 4'd8) begin
          rd_red   <= {bit_r, sh_r[7:1]};
          rd_green <= {bit_g, sh_g[7:1]};
          rd_blue  <= {bit_b, sh_b[7:1]};
          rd_valid <= 1'b1;
        end else if (col_cnt != 4'd0) begin
          sh_r <= {bit_r, sh_r[7:1]};
          sh_g <= {bit_g, sh_g[7:1]};
          sh_b <= {bit_b, sh_b[7:1]};
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_frame_buffer.sv
// tb/tb_matrix_frame_buffer.sv - self-checking bench for matrix_frame_buffer
`timescale 1ns/1ps

module tb_matrix_frame_buffer;

  localparam int PB = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_valid, wr_commit, rd_req;
  logic [5:0]  wr_addr;
  logic [11:0] wr_rgb;
  logic [2:0]  rd_row;
  logic [2:0]  rd_plane;
  logic        wr_ready, commit_pend, rd_busy, rd_valid;
  logic [7:0]  rd_red, rd_blue, rd_green;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: two frame images plus a pending-commit flag.
  logic [11:0] m_front [64];
  logic [11:0] m_back  [64];
  bit          m_pend;

  always #20 clk = ~clk;

  matrix_frame_buffer #(.PWM_BITS(4), .PLANE_W(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_rgb(wr_rgb),
    .wr_commit(wr_commit), .commit_pend(commit_pend),
    .rd_req(rd_req), .rd_row(rd_row), .rd_plane(rd_plane),
    .rd_busy(rd_busy), .rd_valid(rd_valid),
    .rd_red(rd_red), .rd_blue(rd_blue), .rd_green(rd_green)
  );

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear;
    for (int i = 0; i < 64; i++) begin
      m_front[i] = '0;
      m_back[i]  = '0;
    end
    m_pend = 1'b0;
  endtask

  task automatic model_swap;
    logic [11:0] t;
    for (int i = 0; i < 64; i++) begin
      t = m_front[i];
      m_front[i] = m_back[i];
      m_back[i]  = t;
    end
  endtask

  // Byte for one colour: bit c = that channel's intensity bit 'plane' at column c.
  // off: 8 red, 4 green, 0 blue.
  function automatic logic [7:0] exp_byte(input int row, input int plane, input int off);
    logic [7:0]  b;
    logic [11:0] px;
    b = '0;
    for (int c = 0; c < 8; c++) begin
      px = m_front[row*8 + c];
      if (plane < PB) b[c] = px[off + plane];
    end
    return b;
  endfunction

  task automatic wait_clear(input bit poke_commit);
    int cnt, bad;
    cnt = 0;
    bad = 0;
    while (rd_busy === 1'b1 && cnt < 200) begin
      if (wr_ready !== 1'b0 || rd_valid !== 1'b0) bad++;
      if (poke_commit && cnt == 10) wr_commit = 1'b1;
      tick;
      wr_commit = 1'b0;
      cnt++;
    end
    chk("clear_cycles", 32'(cnt), 32'd64);
    chk("clear_ready_valid_low", 32'(bad), 32'd0);
    chk("clear_commit_dropped", 32'(commit_pend), 32'd0);
  endtask

  task automatic do_write(input bit valid, input logic [5:0] a, input logic [11:0] rgb,
                          input bit commit);
    wr_valid  = valid;
    wr_addr   = a;
    wr_rgb    = rgb;
    wr_commit = commit;
    #1;
    chk("wr_ready", 32'(wr_ready), 32'(!m_pend));
    if (valid && !m_pend) m_back[a] = rgb;
    if (commit) m_pend = 1'b1;
    tick;
    wr_valid  = 1'b0;
    wr_commit = 1'b0;
    chk("commit_pend", 32'(commit_pend), 32'(m_pend));
  endtask

  task automatic do_read(input int row, input int plane, input bit inject);
    int lat, extra;
    logic [7:0] er, eg, eb;
    chk("rd_busy_idle", 32'(rd_busy), 32'd0);
    rd_req   = 1'b1;
    rd_row   = 3'(row);
    rd_plane = 3'(plane);
    if (m_pend && row == 0 && plane == 0) begin
      model_swap();
      m_pend = 1'b0;
    end
    tick;
    rd_req = 1'b0;
    chk("pend_after_req", 32'(commit_pend), 32'(m_pend));
    chk("ready_after_req", 32'(wr_ready), 32'(!m_pend));
    lat = 1;
    while (rd_valid !== 1'b1 && lat < 20) begin
      if (inject && lat == 3) begin
        rd_req   = 1'b1;
        rd_row   = 3'd0;
        rd_plane = 3'd0;
      end
      tick;
      rd_req = 1'b0;
      lat++;
    end
    chk("rd_latency", 32'(lat), 32'd10);
    er = exp_byte(row, plane, 8);
    eg = exp_byte(row, plane, 4);
    eb = exp_byte(row, plane, 0);
    chk("rd_red", 32'(rd_red), 32'(er));
    chk("rd_green", 32'(rd_green), 32'(eg));
    chk("rd_blue", 32'(rd_blue), 32'(eb));
    tick;
    chk("rd_valid_one_cycle", 32'(rd_valid), 32'd0);
    chk("rd_red_hold", 32'(rd_red), 32'(er));
    if (inject) begin
      extra = 0;
      for (int i = 0; i < 12; i++) begin
        if (rd_valid === 1'b1) extra++;
        tick;
      end
      chk("busy_req_ignored", 32'(extra), 32'd0);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    wr_valid  = 1'b0;
    wr_commit = 1'b0;
    rd_req    = 1'b0;
    wr_addr   = '0;
    wr_rgb    = '0;
    rd_row    = '0;
    rd_plane  = '0;
    model_clear();
    repeat (3) tick;

    // Reset state
    chk("rst_rd_busy", 32'(rd_busy), 32'd1);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_commit_pend", 32'(commit_pend), 32'd0);
    chk("rst_bytes", 32'({rd_red, rd_green, rd_blue}), 32'd0);

    reset_n = 1'b1;
    wait_clear(1'b1);

    do_read(0, 0, 1'b0);
    chk("first_read_zero", 32'({rd_red, rd_green, rd_blue}), 32'd0);

    // Single pixel, commit, swap, then the documented byte values
    do_write(1'b1, {3'd2, 3'd5}, 12'hF0A, 1'b0);
    do_write(1'b0, 6'd0, 12'h000, 1'b1);
    do_read(0, 0, 1'b0);
    do_read(2, 1, 1'b0);
    chk("px_r2p1_red", 32'(rd_red), 32'h20);
    chk("px_r2p1_blue", 32'(rd_blue), 32'h20);
    chk("px_r2p1_green", 32'(rd_green), 32'h00);
    do_read(2, 0, 1'b0);
    chk("px_r2p0_red", 32'(rd_red), 32'h20);
    chk("px_r2p0_blue", 32'(rd_blue), 32'h00);

    // Uncommitted write stays invisible; commit waits for row0/plane0
    do_write(1'b1, {3'd2, 3'd3}, 12'(($urandom % 4095) + 1), 1'b0);
    do_read(2, 0, 1'b0);
    do_write(1'b0, 6'd0, 12'h000, 1'b1);
    do_read(3, 1, 1'b0);
    chk("row3_keeps_pend", 32'(commit_pend), 32'd1);
    chk("row3_keeps_stall", 32'(wr_ready), 32'd0);
    do_read(0, 0, 1'b0);
    do_read(2, 0, 1'b0);

    // Same-cycle write+commit, stalled write and second commit while pending,
    // request during a fetch, then a single swap
    do_write(1'b1, {3'd6, 3'd1}, 12'hFFF, 1'b1);
    do_write(1'b1, {3'd6, 3'd2}, 12'hFFF, 1'b1);
    do_read(4, 2, 1'b1);
    chk("inject_no_swap", 32'(commit_pend), 32'd1);
    do_read(0, 0, 1'b0);
    do_read(6, 0, 1'b0);
    do_read(0, 0, 1'b0);
    do_read(6, 3, 1'b0);

    // Plane beyond PWM_BITS
    do_write(1'b1, {3'd2, 3'd0}, 12'hFFF, 1'b1);
    do_read(0, 0, 1'b0);
    do_read(2, 5, 1'b0);
    chk("plane5_zero", 32'({rd_red, rd_green, rd_blue}), 32'd0);

    // Randomised frames
    for (int it = 0; it < 25; it++) begin
      int nw;
      nw = int'($urandom_range(0, 12));
      for (int k = 0; k < nw; k++)
        do_write(1'b1, 6'($urandom % 64), 12'($urandom % 4096), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 1) == 1) do_write(1'b0, 6'd0, 12'h000, 1'b1);
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 2) == 0) do_read(0, 0, 1'b0);
        else do_read(int'($urandom % 8), int'($urandom % 8), 1'b0);
      end
    end

    // Make sure the output bytes are non-zero before resetting mid-fetch
    do_write(1'b1, {3'd5, 3'd7}, 12'hFFF, 1'b1);
    do_read(0, 0, 1'b0);
    do_read(5, 0, 1'b0);
    rd_req   = 1'b1;
    rd_row   = 3'd5;
    rd_plane = 3'd0;
    tick;
    rd_req = 1'b0;
    repeat (4) tick;
    reset_n = 1'b0;
    #1;
    chk("midrst_bytes_zero", 32'({rd_red, rd_green, rd_blue}), 32'd0);
    chk("midrst_rd_valid", 32'(rd_valid), 32'd0);
    chk("midrst_rd_busy", 32'(rd_busy), 32'd1);
    chk("midrst_wr_ready", 32'(wr_ready), 32'd0);
    repeat (2) tick;
    reset_n = 1'b1;
    model_clear();
    wait_clear(1'b0);

    // Both buffers must read back as zero
    for (int r = 0; r < 8; r++)
      for (int p = 0; p < 4; p++) do_read(r, p, 1'b0);
    do_write(1'b0, 6'd0, 12'h000, 1'b1);
    do_read(0, 0, 1'b0);
    for (int r = 0; r < 8; r++)
      for (int p = 0; p < 4; p++) do_read(r, p, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
